// File: rtl/activation_writeback_unit.sv
// Activation writeback: takes INT32 accumulators, applies optional ReLU and
// INT8 requantization, and writes the result byte-serially into the activation BRAM.
module activation_writeback_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_values,
  input  logic                  out_mode,
  input  logic [4:0]            shift_amt,
  input  logic                  relu_en,
  input  logic [ACC_WIDTH-1:0]  acc_data,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_write_en,
  output logic [7:0]            bram_write_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           bytes_written,
  output logic                  sat_flag,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCEPT    = 2'd1,
    SERIALIZE = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [15:0]           num_q;
  logic [15:0]           left_q;
  logic                  mode_q;
  logic                  relu_q;
  logic [4:0]            shift_q;
  logic [23:0]           hold_q;
  logic [1:0]            ser_cnt_q;

  // Handshake: a value transfers on a rising edge where acc_valid && acc_ready;
  // acc_ready depends only on state, never on acc_valid.
  logic hs;
  assign acc_ready = (state_q == ACCEPT);
  assign hs        = acc_valid && acc_ready;
  assign dbg_state = state_q;

  logic signed [31:0] v;
  logic signed [32:0] sum;
  logic signed [32:0] rnd;
  logic               sat_hi;
  logic               sat_lo;
  logic [7:0]         q8;

  // Rounding sum is kept in 33 bits so large positive values cannot wrap negative.
  always_comb begin
    v   = (relu_q && acc_data[31]) ? 32'sd0 : $signed(acc_data[31:0]);
    sum = {v[31], v};
    rnd = {v[31], v};
    if (shift_q != 5'd0) begin
      sum = {v[31], v} + (33'sd1 <<< (shift_q - 5'd1));
      rnd = sum >>> shift_q;
    end
    sat_hi = (rnd > 33'sd127);
    sat_lo = (rnd < -33'sd128);
    q8     = sat_hi ? 8'h7F : (sat_lo ? 8'h80 : rnd[7:0]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (num_values == 16'd0) ? DONE : ACCEPT;
      end
      ACCEPT: begin
        if (hs) begin
          if (!mode_q)                state_d = SERIALIZE;
          else if (left_q == 16'd1)   state_d = DONE;
        end
      end
      SERIALIZE: begin
        if (ser_cnt_q == 2'd3) state_d = (left_q == 16'd0) ? DONE : ACCEPT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q        <= '0;
      num_q           <= '0;
      left_q          <= '0;
      mode_q          <= 1'b0;
      relu_q          <= 1'b0;
      shift_q         <= '0;
      hold_q          <= '0;
      ser_cnt_q       <= '0;
      bram_addr       <= '0;
      bram_write_en   <= 1'b0;
      bram_write_data <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      bytes_written   <= '0;
      sat_flag        <= 1'b0;
    end else begin
      bram_write_en <= 1'b0;
      done          <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            wr_ptr_q      <= base_addr;
            num_q         <= num_values;
            left_q        <= num_values;
            mode_q        <= out_mode;
            relu_q        <= relu_en;
            shift_q       <= shift_amt;
            sat_flag      <= 1'b0;
            bytes_written <= '0;
            busy          <= (num_values != 16'd0);
          end
        end
        ACCEPT: begin
          if (hs) begin
            left_q        <= left_q - 16'd1;
            bram_write_en <= 1'b1;
            bram_addr     <= wr_ptr_q;
            wr_ptr_q      <= wr_ptr_q + 1'b1;
            if (mode_q) begin
              bram_write_data <= q8;
              if (sat_hi || sat_lo) sat_flag <= 1'b1;
            end else begin
              bram_write_data <= v[7:0];
              hold_q          <= v[31:8];
              ser_cnt_q       <= 2'd1;
            end
          end
        end
        SERIALIZE: begin
          bram_write_en   <= 1'b1;
          bram_addr       <= wr_ptr_q;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
          bram_write_data <= hold_q[7:0];
          hold_q          <= hold_q >> 8;
          ser_cnt_q       <= ser_cnt_q + 2'd1;
        end
        DONE: begin
          done          <= 1'b1;
          busy          <= 1'b0;
          bytes_written <= mode_q ? num_q : (num_q << 2);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/activation_writeback_unit.md
Name: activation_writeback_unit

Overview:
- Upstream neighbour of the output DMA stage.
- Accepts INT32 accumulator results from the compute unit over a valid/ready stream.
- Applies optional ReLU, and optionally requantizes to INT8 (rounding shift plus saturation).
- Writes the results byte-serially into the BRAM activation buffer that the output DMA later reads.
- On completion reports the number of bytes written, so the controller can program the DMA byte_count directly.

Parameters:
- ADDR_WIDTH, 32, BRAM byte-address width.
- ACC_WIDTH, 32, accumulator width; fixed at 32 for this block.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; latches configuration and begins a writeback.
- base_addr  in  ADDR_WIDTH  BRAM byte address of the first output byte.
- num_values  in  16  number of accumulator values to write back.
- out_mode  in  1  0 = INT32 (4 bytes per value, little-endian); 1 = INT8 requantized (1 byte per value).
- shift_amt  in  5  right-shift amount used in INT8 mode.
- relu_en  in  1  clamp negative values to 0 before quantization.
- acc_data  in  ACC_WIDTH  signed accumulator value.
- acc_valid  in  1  acc_data valid.
- acc_ready  out  1  combinational; equals (state == ACCEPT).
- bram_addr  out  ADDR_WIDTH  registered write address.
- bram_write_en  out  1  registered write strobe; one byte per asserted cycle.
- bram_write_data  out  8  registered write byte.
- busy  out  1  high from the cycle after start until DONE is exited.
- done  out  1  one-cycle pulse.
- bytes_written  out  16  total bytes written; valid when done is high; held until the next start.
- sat_flag  out  1  sticky per transfer: set if any INT8 result saturated; cleared on start.

Behaviour:
- Reset values (async, rst_n low): state IDLE; acc_ready 0; bram_addr 0; bram_write_en 0; bram_write_data 0; busy 0; done 0; bytes_written 0; sat_flag 0.
- Reset mid-transfer aborts immediately. Bytes already written are not undone.
- FSM states:
  - IDLE:
    - On start, latch base_addr, num_values, out_mode, shift_amt and relu_en; clear sat_flag.
    - If num_values == 0: go to DONE with bytes_written = 0.
    - Otherwise: go to ACCEPT, set busy = 1, set bytes_written = 0.
  - ACCEPT: acc_ready = 1. A handshake (acc_valid && acc_ready) at edge T processes the value:
    - ReLU: if relu_en and acc_data < 0, v = 0; else v = acc_data.
    - INT8 mode:
      - If shift_amt > 0, r = (v + (1 << (shift_amt-1))) >>> shift_amt. Arithmetic shift; the sum is computed in 33 bits with no wrap.
      - If shift_amt == 0, r = v.
      - Saturate to [-128, 127] and set sat_flag if clipped.
      - Write the byte at T+1 (bram_write_en = 1). Address increments by 1.
      - Stay in ACCEPT, giving 1 value per cycle throughput.
    - INT32 mode:
      - Write byte 0 (v[7:0]) at T+1 and go to SERIALIZE.
      - SERIALIZE emits v[15:8], v[23:16] and v[31:24] on the next 3 cycles at consecutive addresses, with acc_ready = 0.
      - Then return to ACCEPT, giving 1 value per 4 cycles.
    - After the final value's last byte is issued, go to DONE instead of ACCEPT.
  - SERIALIZE: as described above.
  - DONE:
    - done = 1 for exactly one cycle, in the cycle after the last bram_write_en.
    - bytes_written = num_values × (out_mode ? 1 : 4), truncated to 16 bits.
    - busy drops with done; go to IDLE.
- start is ignored while busy or in DONE.
- acc_valid without ready is ignored. Data is not consumed outside ACCEPT.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is raised.
- Configuration inputs are sampled only at start; mid-transfer changes have no effect.

Test Plan:
1. INT32 mode, base_addr=0x100, num_values=2, values 0x11223344 and -1 → writes 44,33,22,11 at 0x100–0x103 and FF×4 at 0x104–0x107; done pulses once; bytes_written = 8; acc_ready low during SERIALIZE.
2. INT8 mode, shift_amt=4, relu_en=0, values 24, 23, 5000, -5000 → bytes 0x02, 0x01, 0x7F, 0x80 on 4 consecutive cycles; sat_flag = 1; bytes_written = 4.
3. INT8 mode, shift_amt=0, relu_en=1, values -7, 100 → bytes 0x00, 0x64; sat_flag = 0.
4. num_values=0 → no bram_write_en; done pulses 2 cycles after start; bytes_written = 0.
5. acc_valid toggled randomly (bubbles) plus a start re-pulsed mid-transfer → byte sequence and addresses are unchanged; the second start is ignored; exactly one done.
6. rst_n asserted during SERIALIZE → all outputs go to reset values immediately (asynchronously); a subsequent clean transfer succeeds.
